keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad by driving one active-low column at a time and sampling four active-low row lines.
- Column strobe order and encoding match the four-digit display multiplexer: 1110, 1101, 1011, 0111.
- Debounces both press and release, and encodes the key as a 4-bit code.
- Hands the code to the custom processor through a valid/ack handshake. The code can feed the display path directly.

---
 rtl/kp_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// kp_pkg: shared keypad/display types, column strobes and helpers
package kp_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    localparam int KEY_W = 4;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        return idx == 2'd0 ? COL0 : idx == 2'd1 ? COL1 : idx == 2'd2 ? COL2 : COL3;
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] rs);
        return !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous active-low inputs, idles high
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_m;
    logic [W-1:0] r_q;

    // two-stage capture, released lines read as all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= '1;
            r_q <= '1;
        end else begin
            r_m <= i_d;
            r_q <= r_m;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan with press/release debounce and valid/ack key handoff
module keypad_scanner
    import kp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ack,
    output logic             key_held,
    output logic             overrun
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [SW-1:0]    r_slot;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt;
    logic [CW-1:0]    w_inc;
    logic [1:0]       r_col_idx;
    logic [1:0]       w_col_idx;
    logic [1:0]       r_row;
    logic [1:0]       w_row;
    logic [KEY_W-1:0] r_code;
    logic [KEY_W-1:0] w_code;
    logic             r_valid;
    logic             w_valid;
    logic             r_held;
    logic             w_held;
    logic             r_ovr;
    logic             w_ovr;
    logic [3:0]       w_rs;
    logic             w_sp;
    logic             w_hit;

    sync_2ff #(.W(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (row),
        .o_q   (w_rs)
    );

    assign w_sp  = r_slot == SW'(SCAN_DIV - 1);
    assign w_inc = r_cnt + CW'(1);
    assign w_hit = w_inc == CW'(DEBOUNCE_CNT);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SCAN;
        else        r_state <= w_next;
    end

    // next state and next datapath values; only sample points move the scan
    always_comb begin
        w_next    = r_state;
        w_cnt     = r_cnt;
        w_col_idx = r_col_idx;
        w_row     = r_row;
        w_code    = r_code;
        w_valid   = r_valid & ~key_ack;
        w_held    = r_held;
        w_ovr     = 1'b0;
        case (r_state)
            SCAN: begin
                if (w_sp && w_rs != 4'hF) begin
                    w_next = DEBOUNCE;
                    w_cnt  = '0;
                    w_row  = low_row(w_rs);
                end else if (w_sp) begin
                    w_col_idx = r_col_idx + 2'd1;
                end
            end
            DEBOUNCE: begin
                if (w_sp && !w_rs[r_row]) begin
                    w_cnt  = w_inc;
                    w_next = w_hit ? PRESSED : DEBOUNCE;
                end else if (w_sp) begin
                    w_next    = SCAN;
                    w_col_idx = r_col_idx + 2'd1;
                end
            end
            PRESSED: begin
                w_code  = {r_row, r_col_idx};
                w_valid = 1'b1;
                w_held  = 1'b1;
                w_ovr   = r_valid & ~key_ack;
                w_cnt   = '0;
                w_next  = RELEASE;
            end
            RELEASE: begin
                if (w_sp && w_rs == 4'hF) begin
                    w_cnt = w_inc;
                    if (w_hit) begin
                        w_held    = 1'b0;
                        w_next    = SCAN;
                        w_col_idx = r_col_idx + 2'd1;
                    end
                end else if (w_sp) begin
                    w_cnt = '0;
                end
            end
            default: w_next = SCAN;
        endcase
    end

    // slot timer and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot    <= '0;
            r_cnt     <= '0;
            r_col_idx <= '0;
            r_row     <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_held    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_slot    <= w_sp ? '0 : r_slot + SW'(1);
            r_cnt     <= w_cnt;
            r_col_idx <= w_col_idx;
            r_row     <= w_row;
            r_code    <= w_code;
            r_valid   <= w_valid;
            r_held    <= w_held;
            r_ovr     <= w_ovr;
        end
    end

    assign col       = col_strobe(r_col_idx);
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: emulated keypad matrix, random presses, scoreboard-checked handoff
module tb_keypad_scanner;
    import kp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_held;
    logic        overrun;
    logic [15:0] p;

    int checks = 0;
    int failures = 0;
    int q[$];
    logic m_pend = 1'b0;
    logic ph = 1'b0;
    int last_code = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // a row line goes low when a pressed key sits in the currently strobed column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            row[r] = ~|(p[r*4 +: 4] & ~col);
    end

    function automatic logic [3:0] colpat(input int idx);
        logic [3:0] v;
        v = 4'b0001 << (idx % 4);
        return ~v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: each new confirmation pops the scoreboard; handshake tracked at event level
    initial begin : mon
        logic a, rise, eo;
        int e;
        forever begin
            @(posedge clk);
            a = key_ack;
            #1;
            if (!rst_n) begin
                m_pend = 1'b0;
                ph = 1'b0;
            end else begin
                rise = key_held & ~ph;
                eo = rise & m_pend & ~a;
                if (rise) begin
                    if (q.size() == 0) chk("unexpected_key", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("key_code", int'(key_code), e);
                        last_code = e;
                    end
                    m_pend = 1'b1;
                end else if (m_pend && a) begin
                    m_pend = 1'b0;
                end
                chk("key_valid", int'(key_valid), int'(m_pend));
                chk("overrun", int'(overrun), int'(eo));
                if (key_held) chk("col_frozen", int'(col), int'(colpat(last_code % 4)));
                if (ph && !key_held) chk("col_resume", int'(col), int'(colpat(last_code % 4 + 1)));
                ph = key_held;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic press(input logic [15:0] keys, input int mode);
        int e;
        logic ok;
        e = 0;
        for (int i = 15; i >= 0; i--) if (keys[i]) e = i;
        q.push_back(e);
        p = keys;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (mode == 2 && dut.r_state == PRESSED) begin
                key_ack = 1'b1;
                @(negedge clk);
                key_ack = 1'b0;
            end
            if (key_held) ok = 1'b1;
        end
        chk("press_timeout", int'(ok), 1);
        if (mode == 1) begin
            repeat (5) @(negedge clk);
            key_ack = 1'b1;
            @(negedge clk);
            key_ack = 1'b0;
        end
        repeat (8) @(negedge clk);
        p = '0;
        repeat (30) @(negedge clk);
        chk("released", int'(key_held), 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_col"}, int'(col), int'(COL0));
        chk({tag, "_code"}, int'(key_code), 0);
        chk({tag, "_valid"}, int'(key_valid), 0);
        chk({tag, "_held"}, int'(key_held), 0);
        chk({tag, "_ovr"}, int'(overrun), 0);
    endtask

    task automatic wait_state(input state_t s, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (dut.r_state == s) ok = 1'b1;
        end
        chk(name, int'(ok), 1);
    endtask

    initial begin : stim
        logic [15:0] keys;
        int c, m;
        logic ok;
        rst_n = 1'b0;
        key_ack = 1'b0;
        p = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            chk("idle_col", int'(col), int'(colpat((k / 4) % 4)));
        end
        press(16'h0040, 1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (col == COL2 && dut.r_slot == 0) ok = 1'b1;
        end
        chk("bounce_align", int'(ok), 1);
        p = 16'h0040;
        repeat (3) @(negedge clk);
        p = '0;
        repeat (5) @(negedge clk);
        chk("bounce_col", int'(col), int'(COL3));
        chk("bounce_held", int'(key_held), 0);
        press(16'h2002, 1);
        press(16'h0001, 0);
        press(16'h8000, 0);
        press(16'h0020, 2);
        press(16'h0400, 1);
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 9)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                key_ack = 1'b1;
                @(negedge clk);
                key_ack = 1'b0;
            end
            c = $urandom_range(0, 3);
            m = $urandom_range(1, 15);
            keys = '0;
            for (int r = 0; r < 4; r++) if (m[r]) keys[r*4 + c] = 1'b1;
            press(keys, $urandom_range(0, 2));
        end
        p = 16'h0100;
        wait_state(DEBOUNCE, "wait_debounce");
        #2 rst_n = 1'b0;
        #1 check_reset("rst_debounce");
        p = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_spurious_valid", int'(key_valid), 0);
        q.push_back(9);
        p = 16'h0200;
        wait_state(RELEASE, "wait_release");
        #2 rst_n = 1'b0;
        #1 check_reset("rst_release");
        p = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_spurious_valid2", int'(key_valid), 0);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
